led7219_rx: RTL
===============

Name: led7219_rx

Overview:
- Serial receiver/decoder for the MAX7219 daisy-chain protocol that led7219 produces on leds_out/leds_cs/leds_clk.
- Samples the three lines, reassembles each CS-framed chain word and unpacks it into per-device register writes.
- Keeps a 256-bit shadow of all digit registers, in the same layout as led7219's data input.
- Used for loopback checking of the LED debug path on spare exp pins and as a bench monitor.

Parameters:
- NDEV, 4, devices in the chain; each frame carries 16*NDEV bits.
- SYNC_STAGES, 2, synchronizer flops per input line (minimum 2).

Ports:
- clk  input  1  system clock (24 MHz).
- rst  input  1  asynchronous, active-high reset.
- leds_in  input  1  serial data line (DIN), MSB first.
- leds_cs  input  1  load line, active low; a rising edge latches the frame.
- leds_clk  input  1  serial clock; data is sampled on the rising edge.
- wr_valid  output  1  one-cycle strobe for each unpacked device write.
- wr_dev  output  clog2(NDEV)  device index of the write (0 = nearest to DIN source's last word, see Behaviour).
- wr_addr  output  4  register address, taken from bits [11:8] of the 16-bit word.
- wr_data  output  8  register data, taken from bits [7:0] of the word.
- display  output  64*NDEV  shadow of the digit registers.
- shutdown_n  output  NDEV  per-device bit 0 of register 0xC.
- frame_error  output  1  sticky error flag, cleared only by rst.

Behaviour:
- Reset values: all outputs 0, shift register and bit counter cleared, FSM in IDLE, armed=0.
- Input path:
  - Each line passes through SYNC_STAGES flops, then a one-flop edge detector.
  - An event therefore acts SYNC_STAGES+1 cycles after the pin edge.
  - At least 2 clk cycles are required per leds_clk high and low phase.
- Arming: after reset, bits are ignored until leds_cs has been seen high (armed=1). This prevents decoding a frame that was partially sent before reset.
- Shifting: while armed and cs is low, each leds_clk rising edge does sr <= {sr[16*NDEV-2:0], din}.
  - The bit counter increments and saturates at 16*NDEV+1 (overflow marker).
- Frame end (cs rising edge while armed):
  - count == 16*NDEV: copy sr into the hold register, clear the counter, go to UNPACK.
  - count == 0: ignored (glitch or idle toggle), no error.
  - Any other count: frame_error <= 1, frame dropped, counter cleared.
- Chain order: the first word shifted in ends up in the farthest device.
  - Device d therefore owns hold[16*d +: 16]; device 0 is the last word shifted in.
- FSM states: IDLE and UNPACK.
  - UNPACK lasts NDEV cycles, one per device, for d = 0..NDEV-1.
  - Each cycle: wr_valid=1, wr_dev=d, wr_addr=hold[16d+11:16d+8], wr_data=hold[16d+7:16d].
  - After d = NDEV-1 the FSM returns to IDLE.
- Latency: the first wr_valid comes 1 cycle after the cs-rise event; the last comes NDEV cycles after it.
- Shadow update is registered in the same cycle as the corresponding wr_valid:
  - addr 1..8: display[64*d + 8*(addr-1) +: 8] <= data.
  - addr 0xC: shutdown_n[d] <= data[0].
  - addr 0x0 (no-op), 0x9–0xB, 0xD–0xF: strobe only, no shadow change.
  - Bits [15:12] are ignored.
- Simultaneous events:
  - A new valid frame end during UNPACK sets frame_error; the new frame is dropped and the current unpack completes.
  - leds_clk and cs-rise edges in the same cycle: the clock edge shifts first, then the cs-rise is evaluated with the updated count.
  - A cs-fall during UNPACK is legal; shifting uses sr, which is independent of hold.
- Reset mid-operation: asynchronous clear of everything, including display and the sticky error. A strobe in flight is aborted.

Decomposition:
- Shared package `led7219_pkg`:
  - MAX7219 register address constants: NOOP=0, DIGIT0=1, DECODE=9, INTENSITY=0xA, SCANLIMIT=0xB, SHUTDOWN=0xC, TEST=0xF.
  - WORD_BITS=16, DIGITS=8.
  - Shared with led7219.
- One sub-module, `sync_edge` (N-stage synchronizer plus rise/fall detect), instantiated three times.
- FSM and shadow logic stay in led7219_rx.

Test Plan:
- Reset, then drive cs high, then one frame with NDEV=4 of words 0x0155, 0x0200, 0x0C01, 0x08FF (first shifted to last):
  - 4 strobes: dev0 addr8 data 0xFF; dev1 addr0xC data 0x01; dev2 addr2 data 0x00; dev3 addr1 data 0x55.
  - display[7:0]=0, display[63:56]=0xFF, display[199:192]=0x55, shutdown_n=4'b0010.
- Frame of 63 bits, then cs rise: frame_error=1, no wr_valid, display unchanged; a following good frame still decodes, and frame_error stays 1.
- Assert rst with cs low mid-frame (20 bits sent), release, and continue 44 bits with cs still low, then cs rise: no strobes and no error (not armed); the next full frame decodes normally.
- All four words set to addr 0x0 (no-op): 4 strobes with wr_addr=0, display and shutdown_n unchanged.
- cs pulsed low/high with no clocks: no strobe, no error.
- leds_clk at the minimum 2+2 cycles per bit, back-to-back frames with cs high for 2 cycles: every frame unpacks, frame_error stays 0.

Source files
------------

// File: rtl/led7219_pkg.sv
// Shared MAX7219 definitions: register map, word geometry and receiver FSM states.
package led7219_pkg;
    localparam int WORD_BITS = 16;
    localparam int DIGITS    = 8;

    localparam logic [3:0] NOOP      = 4'h0;
    localparam logic [3:0] DIGIT0    = 4'h1;
    localparam logic [3:0] DECODE    = 4'h9;
    localparam logic [3:0] INTENSITY = 4'hA;
    localparam logic [3:0] SCANLIMIT = 4'hB;
    localparam logic [3:0] SHUTDOWN  = 4'hC;
    localparam logic [3:0] TEST      = 4'hF;

    typedef enum logic {IDLE, UNPACK} rx_state_t;
endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for one asynchronous line, followed by rise/fall detection.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/led7219_rx.sv
// MAX7219 chain receiver: reassembles CS-framed chain words, replays them as
// per-device register writes and mirrors the digit/shutdown registers.
module led7219_rx
    import led7219_pkg::*;
#(
    parameter int NDEV        = 4,
    parameter int SYNC_STAGES = 2,
    localparam int DW = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 leds_in,
    input  logic                 leds_cs,
    input  logic                 leds_clk,
    output logic                 wr_valid,
    output logic [DW-1:0]        wr_dev,
    output logic [3:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic [64*NDEV-1:0]   display,
    output logic [NDEV-1:0]      shutdown_n,
    output logic                 frame_error
);
    localparam int FB = WORD_BITS * NDEV;
    localparam int CW = $clog2(FB + 2);

    logic din_lvl, cs_lvl, cs_rise, sclk_rise;
    logic din_unused_r, din_unused_f, cs_unused_f, sclk_unused_l, sclk_unused_f;

    sync_edge #(.STAGES(SYNC_STAGES)) u_din (
        .clk(clk), .rst(rst), .d(leds_in),
        .level(din_lvl), .rise(din_unused_r), .fall(din_unused_f));
    sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst(rst), .d(leds_cs),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_unused_f));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .d(leds_clk),
        .level(sclk_unused_l), .rise(sclk_rise), .fall(sclk_unused_f));

    logic            armed, shift, frame_end, frame_ok;
    logic [FB-1:0]   sr, sr_n, hold;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   idx;
    logic [15:0]     word;
    rx_state_t       state, state_n;

    // A clock edge coinciding with cs-rise still belongs to the closing frame.
    always_comb begin
        shift     = armed && sclk_rise && (!cs_lvl || cs_rise);
        sr_n      = shift ? {sr[FB-2:0], din_lvl} : sr;
        cnt_n     = cnt;
        if (shift && cnt != CW'(FB + 1))
            cnt_n = cnt + 1'b1;
        frame_end = armed && cs_rise;
        frame_ok  = frame_end && (cnt_n == CW'(FB)) && (state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b0;
            sr          <= '0;
            cnt         <= '0;
            hold        <= '0;
            frame_error <= 1'b0;
        end else begin
            armed <= armed | cs_lvl;
            sr    <= sr_n;
            cnt   <= frame_end ? '0 : cnt_n;
            if (frame_ok)
                hold <= sr_n;
            if (frame_end && cnt_n != '0 && !frame_ok)
                frame_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= (state == UNPACK && idx != DW'(NDEV - 1)) ? idx + 1'b1 : '0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_ok) state_n = UNPACK;
            UNPACK:  if (idx == DW'(NDEV - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        word     = hold[WORD_BITS*idx +: WORD_BITS];
        wr_valid = (state == UNPACK);
        wr_dev   = wr_valid ? idx : '0;
        wr_addr  = wr_valid ? word[11:8] : 4'h0;
        wr_data  = wr_valid ? word[7:0] : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display    <= '0;
            shutdown_n <= '0;
        end else if (wr_valid) begin
            for (int d = 0; d < NDEV; d++) begin
                if (wr_dev == DW'(d)) begin
                    for (int a = 0; a < DIGITS; a++)
                        if (wr_addr == 4'(DIGIT0 + a))
                            display[64*d + 8*a +: 8] <= wr_data;
                    if (wr_addr == SHUTDOWN)
                        shutdown_n[d] <= wr_data[0];
                end
            end
        end
    end
endmodule
